elevator_controller: RTL and testbench
======================================

# elevator_controller

Four-floor elevator control FSM. Latches floor call requests, sweeps the car up or down one floor at a time on a travel timer, and opens the door for a fixed time at each requested floor. Its `floor_code` output drives the 7-segment floor display decoder directly. The motion and door outputs go to the car indicators.

## Interface
Parameters:
- `TRAVEL_CYCLES`, default 4: clock cycles to move one floor; must be ≥ 1.
- `DOOR_CYCLES`, default 3: clock cycles the door stays open; must be ≥ 1.

Ports:
- `clk` in 1: the only clock. All state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req` in 4: floor call buttons. Bit *i* requests floor *i*. A level is sampled each edge, so a 1-cycle pulse is enough.
- `floor_code` out 2: current car floor, 0–3.
- `moving_up` out 1: high while in MOVE_UP.
- `moving_down` out 1: high while in MOVE_DOWN.
- `door_open` out 1: high while in DOOR_OPEN.
- `pending` out 4: latched outstanding requests.

## Operation
- **Reset values** (edge with `rst_n` = 0, which wins over everything):
  - state IDLE, `floor_code` = 0, `pending` = 0.
  - all motion and door outputs 0, both counters 0.
  - last direction = UP.
- **Request latch:** each edge, `pending <= (pending | req) & ~clear`.
  - `clear` is the one-hot of the floor where the door opens on that edge, or is held open.
  - Clear wins over a simultaneous `req` bit for that floor.
- **State decisions** use the registered `pending`, never raw `req`.
- **IDLE:**
  - If `pending[floor]` is set: go to DOOR_OPEN and clear that bit.
  - Otherwise, if last direction is UP and any pending bit is above: MOVE_UP.
  - Otherwise, if any pending bit is below: MOVE_DOWN.
  - Otherwise, if any pending bit is above: MOVE_UP.
  - Otherwise stay in IDLE.
  - Last direction updates on entering either move state.
- **MOVE_UP / MOVE_DOWN:**
  - The travel counter counts 0 .. `TRAVEL_CYCLES`−1.
  - On the edge where it equals `TRAVEL_CYCLES`−1, `floor_code` steps ±1 and the counter returns to 0.
  - On that same edge, if the new floor is pending, go to DOOR_OPEN and clear its bit. Otherwise keep moving.
  - A request always remains beyond the car, so the car never moves past floor 3 or below floor 0.
  - Requests behind the car are latched and served after it reverses.
- **DOOR_OPEN:**
  - The door counter counts 0 .. `DOOR_CYCLES`−1, then the state goes to IDLE.
  - A `req` for the current floor while the door is open restarts the door counter to 0 and is not latched.
- **Mid-operation reset:** a reset during motion or door-open returns the car to floor 0 immediately. No graceful stop.

## Timing
- Latency from `req` to `pending`: 1 edge.
- Latency from `pending` to leaving IDLE: 1 edge.
- One floor of travel takes exactly `TRAVEL_CYCLES` cycles.
- The door stays open for exactly `DOOR_CYCLES` cycles when not restarted.
- After the door closes, the car spends 1 IDLE cycle before the next move.
- All outputs are registered or decoded only from registered state; there are no combinational paths from `req` to any output.

## Structure
- `elevator_pkg` holds:
  - the state enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN);
  - `NUM_FLOORS` = 4 and `FLOOR_W` = 2;
  - the direction enum.
- Sub-module `elevator_timer`: a loadable terminal counter, instantiated once for travel and once for the door. Ports: `clear`, `enable`, `limit`, `done`.
- The "pending above/below current floor" masks are combinational logic inside the top module.

## Test plan
With `TRAVEL_CYCLES` = 4 and `DOOR_CYCLES` = 3:
1. Reset, then pulse `req` = 0100 at edge 1.
   - `pending` = 0100 after edge 1.
   - `moving_up` from edge 2.
   - `floor_code` = 1 at edge 6, then 2 at edge 10 together with `door_open` = 1 and `pending` = 0.
   - `door_open` low and IDLE at edge 13.
2. From idle at floor 0, pulse `req` = 0001.
   - Door opens next decision edge.
   - `floor_code` stays 0 and no motion output ever goes high.
3. Car moving up from floor 1 toward floor 3; pulse `req` = 0001 mid-travel.
   - The car reaches floor 3 and the door opens.
   - After the door closes: 1 IDLE cycle, then MOVE_DOWN, arriving at floor 0 after 12 cycles of travel.
4. Door open at floor 2; pulse `req` = 0100 on door cycle 2.
   - Door counter restarts, so `door_open` stays high 5 cycles in total.
   - `pending[2]` stays 0.
5. `req` = 1010 held high while at floor 1 idle.
   - Door opens at 1 first.
   - Then MOVE_UP, with floor 2 passed without stopping, and the door opens at 3.
6. Assert `rst_n` = 0 for one edge mid-travel at floor 2.
   - All outputs return to their reset values on that edge, including `floor_code` = 0 and `pending` = 0.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the four-floor elevator controller.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package elevator_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // One-hot mask selecting a single floor.
    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
        floor_onehot    = '0;
        floor_onehot[f] = 1'b1;
    endfunction

endpackage

// File: rtl/elevator_timer.sv
// Terminal counter: counts 0..limit while enabled, flags done at limit, then wraps to 0.
// Latency: done is decoded from the registered count (no input-to-output path except enable gating).
// Backpressure: none; clear has priority over enable and forces the count back to 0.
module elevator_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] count;

    assign done = enable && (count == limit);

    // Count up while enabled, wrap at the limit, restart on clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= done ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/elevator_controller.sv
// Four-floor elevator FSM: latches calls, sweeps one floor per travel period, opens door at called floors.
// Latency: req->pending 1 edge, pending->leaving IDLE 1 edge; all outputs registered.
// Backpressure: none; req is a level sampled every edge, a one-cycle pulse is enough.
module elevator_controller
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]    floor_code,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);

    state_t                  state;
    dir_t                    last_dir;
    logic [NUM_FLOORS-1:0]   pend_above;
    logic [NUM_FLOORS-1:0]   pend_below;
    logic [NUM_FLOORS-1:0]   clear_mask;
    logic [FLOOR_W-1:0]      step_floor;
    logic                    in_motion;
    logic                    in_door;
    logic                    door_restart;
    logic                    travel_done;
    logic                    door_done;

    assign in_motion    = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign in_door      = (state == DOOR_OPEN);
    // A call for the floor the door is already open at just holds the door longer.
    assign door_restart = in_door && req[floor_code];

    elevator_timer #(.W(CNT_W)) u_travel_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!in_motion),
        .enable (in_motion),
        .limit  (CNT_W'(TRAVEL_CYCLES - 1)),
        .done   (travel_done)
    );

    elevator_timer #(.W(CNT_W)) u_door_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!in_door || door_restart),
        .enable (in_door),
        .limit  (CNT_W'(DOOR_CYCLES - 1)),
        .done   (door_done)
    );

    // Pending-call masks relative to the car, the floor reached on the next step, and the floor to clear.
    always_comb begin
        pend_above = '0;
        pend_below = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            pend_above[i] = pending[i] && (FLOOR_W'(i) > floor_code);
            pend_below[i] = pending[i] && (FLOOR_W'(i) < floor_code);
        end

        step_floor = (state == MOVE_DOWN) ? floor_code - 1'b1 : floor_code + 1'b1;

        clear_mask = '0;
        case (state)
            IDLE:      if (pending[floor_code]) clear_mask = floor_onehot(floor_code);
            MOVE_UP,
            MOVE_DOWN: if (travel_done && pending[step_floor]) clear_mask = floor_onehot(step_floor);
            DOOR_OPEN: clear_mask = floor_onehot(floor_code);
            default:   clear_mask = '0;
        endcase
    end

    // Call latch: new requests accumulate, the floor being served is dropped (clear wins).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending | req) & ~clear_mask;
        end
    end

    // Main control FSM with registered motion/door indicators and floor position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            floor_code  <= '0;
            last_dir    <= DIR_UP;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
            door_open   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending[floor_code]) begin
                        state     <= DOOR_OPEN;
                        door_open <= 1'b1;
                    end else if ((last_dir == DIR_UP) && (|pend_above)) begin
                        state     <= MOVE_UP;
                        moving_up <= 1'b1;
                        last_dir  <= DIR_UP;
                    end else if (|pend_below) begin
                        state       <= MOVE_DOWN;
                        moving_down <= 1'b1;
                        last_dir    <= DIR_DOWN;
                    end else if (|pend_above) begin
                        state     <= MOVE_UP;
                        moving_up <= 1'b1;
                        last_dir  <= DIR_UP;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (travel_done) begin
                        floor_code <= step_floor;
                        if (pending[step_floor]) begin
                            state       <= DOOR_OPEN;
                            moving_up   <= 1'b0;
                            moving_down <= 1'b0;
                            door_open   <= 1'b1;
                        end else if ((state == MOVE_UP   && step_floor == FLOOR_W'(NUM_FLOORS - 1)) ||
                                     (state == MOVE_DOWN && step_floor == '0)) begin
                            // Defensive stop at the shaft ends; a call beyond the car normally prevents this.
                            state       <= IDLE;
                            moving_up   <= 1'b0;
                            moving_down <= 1'b0;
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (door_done && !door_restart) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    moving_up   <= 1'b0;
                    moving_down <= 1'b0;
                    door_open   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller: table-driven cycle vectors plus hand-written door-restart and long-travel sequences.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_elevator_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [1:0] floor_code;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;
    logic [3:0] pending;

    int total;
    int passed;

    elevator_controller #(
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .floor_code  (floor_code),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_open   (door_open),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rst_n/req are applied for the first edge only, then idle for the remaining cyc-1 edges.
    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        int         cyc;
        logic [1:0] floor;
        logic       up;
        logic       dn;
        logic       door;
        logic [3:0] pend;
    } vec_t;

    vec_t vecs[33];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input int c, input logic [1:0] f,
                                input logic u, input logic d, input logic o, input logic [3:0] p);
        vec_t v;
        v.rst_n = r; v.req = q; v.cyc = c; v.floor = f;
        v.up = u; v.dn = d; v.door = o; v.pend = p;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            rst_n = vecs[k].rst_n;
            req   = vecs[k].req;
            step(1);
            rst_n = 1'b1;
            req   = 4'b0000;
            if (vecs[k].cyc > 1) step(vecs[k].cyc - 1);
            check($sformatf("v%0d floor", k),   {2'b00, floor_code}, {2'b00, vecs[k].floor});
            check($sformatf("v%0d up", k),      {3'b000, moving_up},   {3'b000, vecs[k].up});
            check($sformatf("v%0d down", k),    {3'b000, moving_down}, {3'b000, vecs[k].dn});
            check($sformatf("v%0d door", k),    {3'b000, door_open},   {3'b000, vecs[k].door});
            check($sformatf("v%0d pending", k), pending, vecs[k].pend);
        end
    endtask

    initial begin
        int  cnt;
        logic pend_leak;

        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        req    = 4'b0000;

        //               rst  req     cyc fl up dn door pend
        // Reset, then call floor 2 from floor 0.
        vecs[0]  = mk(0, 4'b0000, 2, 0, 0, 0, 0, 4'b0000);
        vecs[1]  = mk(1, 4'b0100, 1, 0, 0, 0, 0, 4'b0100);
        vecs[2]  = mk(1, 4'b0000, 1, 0, 1, 0, 0, 4'b0100);
        vecs[3]  = mk(1, 4'b0000, 4, 1, 1, 0, 0, 4'b0100);
        vecs[4]  = mk(1, 4'b0000, 3, 1, 1, 0, 0, 4'b0100);
        vecs[5]  = mk(1, 4'b0000, 1, 2, 0, 0, 1, 4'b0000);
        vecs[6]  = mk(1, 4'b0000, 2, 2, 0, 0, 1, 4'b0000);
        vecs[7]  = mk(1, 4'b0000, 1, 2, 0, 0, 0, 4'b0000);
        // From floor 2 call floor 1 (down).
        vecs[8]  = mk(1, 4'b0010, 1, 2, 0, 0, 0, 4'b0010);
        vecs[9]  = mk(1, 4'b0000, 1, 2, 0, 1, 0, 4'b0010);
        vecs[10] = mk(1, 4'b0000, 3, 2, 0, 1, 0, 4'b0010);
        vecs[11] = mk(1, 4'b0000, 1, 1, 0, 0, 1, 4'b0000);
        vecs[12] = mk(1, 4'b0000, 3, 1, 0, 0, 0, 4'b0000);
        // req=1010 held two edges at floor 1; then a floor-0 call mid-travel up.
        vecs[13] = mk(1, 4'b1010, 1, 1, 0, 0, 0, 4'b1010);
        vecs[14] = mk(1, 4'b1010, 1, 1, 0, 0, 1, 4'b1000);
        vecs[15] = mk(1, 4'b0000, 3, 1, 0, 0, 0, 4'b1000);
        vecs[16] = mk(1, 4'b0000, 1, 1, 1, 0, 0, 4'b1000);
        vecs[17] = mk(1, 4'b0001, 1, 1, 1, 0, 0, 4'b1001);
        vecs[18] = mk(1, 4'b0000, 3, 2, 1, 0, 0, 4'b1001);
        vecs[19] = mk(1, 4'b0000, 4, 3, 0, 0, 1, 4'b0001);
        vecs[20] = mk(1, 4'b0000, 3, 3, 0, 0, 0, 4'b0001);
        // Door at floor 0 closes; then a call at the current floor: door only, no motion.
        vecs[21] = mk(1, 4'b0000, 3, 0, 0, 0, 0, 4'b0000);
        vecs[22] = mk(1, 4'b0001, 1, 0, 0, 0, 0, 4'b0001);
        vecs[23] = mk(1, 4'b0000, 1, 0, 0, 0, 1, 4'b0000);
        vecs[24] = mk(1, 4'b0000, 1, 0, 0, 0, 1, 4'b0000);
        vecs[25] = mk(1, 4'b0000, 1, 0, 0, 0, 1, 4'b0000);
        vecs[26] = mk(1, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);
        // Travel toward floor 3, reset while passing floor 2 (req during reset is dropped).
        vecs[27] = mk(1, 4'b1000, 1, 0, 0, 0, 0, 4'b1000);
        vecs[28] = mk(1, 4'b0000, 1, 0, 1, 0, 0, 4'b1000);
        vecs[29] = mk(1, 4'b0000, 8, 2, 1, 0, 0, 4'b1000);
        vecs[30] = mk(1, 4'b0000, 1, 2, 1, 0, 0, 4'b1000);
        vecs[31] = mk(0, 4'b1111, 1, 0, 0, 0, 0, 4'b0000);
        vecs[32] = mk(1, 4'b0000, 3, 0, 0, 0, 0, 4'b0000);

        run_range(0, 7);

        // Door restart: call floor 2 while idle there, re-press on door cycle 2.
        req = 4'b0100;
        step(1);
        req = 4'b0000;
        check("restart pending latched", pending, 4'b0100);
        step(1);
        cnt       = 0;
        pend_leak = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!door_open) break;
            cnt++;
            if (pending[2]) pend_leak = 1'b1;
            req = (i == 1) ? 4'b0100 : 4'b0000;
            step(1);
        end
        req = 4'b0000;
        check("restart door cycles", 4'(cnt), 4'd5);
        check("restart pending[2] stays 0", {3'b000, pend_leak}, 4'b0000);
        check("restart door closed", {3'b000, door_open}, 4'b0000);

        run_range(8, 20);

        // Reverse after serving floor 3: one idle cycle, then 12 cycles of downward travel.
        step(1);
        check("reverse moving_down after idle", {3'b000, moving_down}, 4'b0001);
        check("reverse floor before travel", {2'b00, floor_code}, 4'd3);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!moving_down) break;
            cnt++;
            step(1);
        end
        check("reverse travel cycles", 4'(cnt), 4'd12);
        check("reverse arrive floor", {2'b00, floor_code}, 4'd0);
        check("reverse arrive door", {3'b000, door_open}, 4'b0001);
        check("reverse arrive pending", pending, 4'b0000);

        run_range(21, 32);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
